// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: trap codes, machine CSR addresses,
// mcause values, FSM/kind encodings and small decode helpers.
package trap_sequencer_pkg;

    localparam logic [1:0] TRAP_NONE  = 2'b00;
    localparam logic [1:0] TRAP_ECALL = 2'b01;
    localparam logic [1:0] TRAP_UNIMP = 2'b10;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] MCAUSE_ECALL   = 32'd11;
    localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DRAIN    = 2'b01,
        ST_COMMIT   = 2'b10,
        ST_REDIRECT = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'b00,
        KIND_ECALL = 2'b01,
        KIND_UNIMP = 2'b10,
        KIND_MRET  = 2'b11
    } kind_e;

    // Unimplemented beats ecall beats mret when decode flags several at once.
    function automatic kind_e decode_kind(input logic ecall, input logic unimp,
                                          input logic mret);
        kind_e k;
        if (unimp) begin
            k = KIND_UNIMP;
        end else if (ecall) begin
            k = KIND_ECALL;
        end else if (mret) begin
            k = KIND_MRET;
        end else begin
            k = KIND_NONE;
        end
        return k;
    endfunction

    function automatic logic [1:0] trap_code(input kind_e k);
        logic [1:0] c;
        case (k)
            KIND_ECALL: c = TRAP_ECALL;
            KIND_UNIMP: c = TRAP_UNIMP;
            default:    c = TRAP_NONE;
        endcase
        return c;
    endfunction

    // mtvec is used in direct mode only, so its mode bits are dropped.
    function automatic logic [31:0] redirect_target(input kind_e k,
                                                    input logic [31:0] mtvec,
                                                    input logic [31:0] mepc);
        logic [31:0] t;
        if (k == KIND_MRET) begin
            t = {mepc[31:1], 1'b0};
        end else begin
            t = {mtvec[31:2], 2'b00};
        end
        return t;
    endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Sequences ecall/unimp/mret: freezes the front end, drains older instructions,
// pulses the trap code to the CSR file and then redirects fetch.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_ecall,
    input  logic        id_unimp,
    input  logic        id_mret,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic [1:0]  trap,
    output logic [31:0] trap_pc,
    output logic        busy,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;

    logic [1:0]  trap_q, trap_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        busy_q, busy_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        event_s;

    assign event_s = id_valid & (id_unimp | id_ecall | id_mret);

    // Next-state and next-output logic; every output lags its state by one edge.
    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        cnt_d            = cnt_q;
        pc_d             = pc_q;
        trap_d           = TRAP_NONE;
        trap_pc_d        = 32'h0000_0000;
        busy_d           = (state_q != ST_IDLE);
        flush_d          = (state_q == ST_DRAIN);
        redirect_valid_d = (state_q == ST_REDIRECT);
        redirect_pc_d    = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                if (event_s) begin
                    state_d = ST_DRAIN;
                    kind_d  = decode_kind(id_ecall, id_unimp, id_mret);
                    cnt_d   = CNT_LOAD;
                    pc_d    = id_pc;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = (kind_q == KIND_MRET) ? ST_REDIRECT : ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                trap_d    = trap_code(kind_q);
                trap_pc_d = pc_q;
                state_d   = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                // CSR values are sampled here, after the CSR file has taken the trap.
                redirect_pc_d = redirect_target(kind_q, csr_mtvec, csr_mepc);
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            kind_q           <= KIND_NONE;
            cnt_q            <= {CNT_W{1'b0}};
            pc_q             <= 32'h0000_0000;
            trap_q           <= TRAP_NONE;
            trap_pc_q        <= 32'h0000_0000;
            busy_q           <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            cnt_q            <= cnt_d;
            pc_q             <= pc_d;
            trap_q           <= trap_d;
            trap_pc_q        <= trap_pc_d;
            busy_q           <= busy_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign trap           = trap_q;
    assign trap_pc        = trap_pc_q;
    assign busy           = busy_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus random traffic
// compared cycle by cycle against an event-timeline reference model.
module tb_trap_sequencer;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ecall, id_unimp, id_mret;
    logic [31:0] id_pc, csr_mtvec, csr_mepc;
    logic [1:0]  trap;
    logic [31:0] trap_pc, redirect_pc;
    logic        busy, flush, redirect_valid;

    logic        v1, e1;
    logic [31:0] pc1, mtvec1;
    logic [1:0]  trap1;
    logic [31:0] trap_pc1, redirect_pc1;
    logic        busy1, flush1, rv1;

    always #5 clk = ~clk;

    trap_sequencer #(.DRAIN_CYCLES(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_ecall(id_ecall), .id_unimp(id_unimp), .id_mret(id_mret),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .trap(trap), .trap_pc(trap_pc),
        .busy(busy), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    trap_sequencer #(.DRAIN_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(v1), .id_pc(pc1),
        .id_ecall(e1), .id_unimp(1'b0), .id_mret(1'b0),
        .csr_mtvec(mtvec1), .csr_mepc(32'h0000_0000), .trap(trap1), .trap_pc(trap_pc1),
        .busy(busy1), .flush(flush1), .redirect_valid(rv1),
        .redirect_pc(redirect_pc1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: one accepted event described by its edge and duration
    int          ev_edge = -1;
    int          ev_len = 0;
    bit          ev_mret = 1'b0;
    logic [1:0]  ev_code = 2'b00;
    logic [31:0] ev_pc = 32'h0;
    logic [31:0] exp_rpc = 32'h0;
    int          next_ok = 0;

    logic [31:0] mcause_m = 32'h0;
    int          trap_pulses = 0;
    int          rv_pulses = 0;
    int          last_trap_cyc = -1;
    int          t_trap, t_rv;
    logic [31:0] rpc_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        cyc++;
        if (rst) begin
            ev_edge = -1;
            next_ok = 0;
        end else if (cyc >= next_ok && id_valid && (id_unimp || id_ecall || id_mret)) begin
            ev_edge = cyc;
            ev_mret = !id_unimp && !id_ecall;
            ev_code = id_unimp ? 2'b10 : (id_ecall ? 2'b01 : 2'b00);
            ev_len  = ev_mret ? D + 1 : D + 2;
            ev_pc   = id_pc;
            next_ok = cyc + ev_len + 1;
        end
        if (ev_edge >= 0 && cyc == ev_edge + ev_len) begin
            exp_rpc = ev_mret ? {csr_mepc[31:1], 1'b0} : {csr_mtvec[31:2], 2'b00};
        end
    endtask

    task automatic check_outputs();
        bit         act;
        bit         busy_e, flush_e, rv_e;
        logic [1:0] trap_e;
        act     = (ev_edge >= 0);
        busy_e  = act && cyc >= ev_edge + 1 && cyc <= ev_edge + ev_len;
        flush_e = act && cyc >= ev_edge + 1 && cyc <= ev_edge + D;
        trap_e  = (act && !ev_mret && cyc == ev_edge + D + 1) ? ev_code : 2'b00;
        rv_e    = act && cyc == ev_edge + ev_len;
        chk("busy", 32'(busy), 32'(busy_e));
        chk("flush", 32'(flush), 32'(flush_e));
        chk("trap", 32'(trap), 32'(trap_e));
        if (trap_e != 2'b00) chk("trap_pc", trap_pc, ev_pc);
        chk("redirect_valid", 32'(redirect_valid), 32'(rv_e));
        if (rv_e) chk("redirect_pc", redirect_pc, exp_rpc);
        // CSR file: latches mepc/mcause on the falling edge of the trap cycle
        if (trap == 2'b01) begin
            csr_mepc = trap_pc; mcause_m = 32'd11;
        end else if (trap == 2'b10) begin
            csr_mepc = trap_pc; mcause_m = 32'd2;
        end
        if (trap != 2'b00) begin
            trap_pulses++; last_trap_cyc = cyc;
        end
        if (redirect_valid) rv_pulses++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_id();
        id_valid = 1'b0; id_ecall = 1'b0; id_unimp = 1'b0; id_mret = 1'b0;
    endtask

    task automatic async_reset_check();
        rst = 1'b1;
        #1;
        chk("rst_trap", 32'(trap), 32'h0);
        chk("rst_trap_pc", trap_pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_rv", 32'(redirect_valid), 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
    endtask

    task automatic watch(input int n, input int k);
        t_trap = -1; t_rv = -1; rpc_seen = 32'h0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (trap != 2'b00 && t_trap < 0) t_trap = cyc - k;
            if (redirect_valid && t_rv < 0) begin
                t_rv = cyc - k; rpc_seen = redirect_pc;
            end
        end
    endtask

    initial begin
        int k;
        rst = 1'b1;
        clear_id();
        id_pc = 32'h0; csr_mtvec = 32'h0; csr_mepc = 32'h0;
        v1 = 1'b0; e1 = 1'b0; pc1 = 32'h0; mtvec1 = 32'h0;
        async_reset_check();
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle();

        // 1: ecall at 0x100 with mtvec 0x804
        csr_mtvec = 32'h804; id_valid = 1'b1; id_ecall = 1'b1; id_pc = 32'h100;
        cycle(); k = cyc; clear_id();
        watch(7, k);
        chk("t1_trap_at", 32'(t_trap), 32'd4);
        chk("t1_redir_at", 32'(t_rv), 32'd5);
        chk("t1_redir_pc", rpc_seen, 32'h804);
        chk("t1_mepc", csr_mepc, 32'h100);
        chk("t1_mcause", mcause_m, 32'd11);

        // 2: unimp and ecall together, mtvec low bits set
        csr_mtvec = 32'h203; id_valid = 1'b1; id_ecall = 1'b1; id_unimp = 1'b1; id_pc = 32'h40;
        cycle(); k = cyc; clear_id();
        watch(7, k);
        chk("t2_redir_pc", rpc_seen, 32'h200);
        chk("t2_mepc", csr_mepc, 32'h40);
        chk("t2_mcause", mcause_m, 32'd2);

        // 3: mret
        csr_mepc = 32'h105; trap_pulses = 0;
        id_valid = 1'b1; id_mret = 1'b1; id_pc = 32'h77c;
        cycle(); k = cyc; clear_id();
        watch(6, k);
        chk("t3_redir_at", 32'(t_rv), 32'd4);
        chk("t3_redir_pc", rpc_seen, 32'h104);
        chk("t3_no_trap", 32'(trap_pulses), 32'd0);

        // 4: ecall held by the stalled decode slot
        csr_mtvec = 32'h900; id_valid = 1'b1; id_ecall = 1'b1; id_pc = 32'h300;
        cycle(); k = cyc; trap_pulses = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t4_one_pulse", 32'(trap_pulses), 32'd1);
        cycle();
        clear_id();
        for (int i = 0; i < 8; i++) cycle();
        chk("t4_two_pulses", 32'(trap_pulses), 32'd2);
        chk("t4_second_at", 32'(last_trap_cyc - k), 32'd10);

        // 5: reset during DRAIN
        id_valid = 1'b1; id_ecall = 1'b1; id_pc = 32'h500;
        cycle(); clear_id();
        cycle(); cycle();
        chk("t5_busy_before", 32'(busy), 32'h1);
        async_reset_check();
        cycle();
        rst = 1'b0; trap_pulses = 0; rv_pulses = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("t5_no_trap", 32'(trap_pulses), 32'd0);
        chk("t5_no_redir", 32'(rv_pulses), 32'd0);

        // 6: single-cycle drain build
        mtvec1 = 32'h804; v1 = 1'b1; e1 = 1'b1; pc1 = 32'h100;
        cycle(); v1 = 1'b0; e1 = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            cycle();
            chk($sformatf("t6_trap_e%0d", j), 32'(trap1), (j == 2) ? 32'h1 : 32'h0);
            chk($sformatf("t6_rv_e%0d", j), 32'(rv1), (j == 3) ? 32'h1 : 32'h0);
            if (j == 2) chk("t6_trap_pc", trap_pc1, 32'h100);
            if (j == 3) chk("t6_redir_pc", redirect_pc1, 32'h804);
        end

        // random traffic, with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset_check();
                cycle();
                rst = 1'b0;
            end else begin
                id_valid  = 1'($urandom_range(0, 1));
                id_ecall  = ($urandom_range(0, 3) == 0);
                id_unimp  = ($urandom_range(0, 3) == 0);
                id_mret   = ($urandom_range(0, 2) == 0);
                id_pc     = $urandom;
                csr_mtvec = $urandom;
                if ($urandom_range(0, 7) == 0) csr_mepc = $urandom;
                cycle();
            end
        end
        clear_id();
        for (int i = 0; i < 8; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
